// File: rtl/phys_reg_file_pkg.sv
// rtl/phys_reg_file_pkg.sv - shared types and defaults for the physical register file
package phys_reg_file_pkg;
  localparam int NUM_PHY_REGS_DEF = 64;
  localparam int NUM_ARCH_DEF     = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int PR_W             = $clog2(NUM_PHY_REGS_DEF);

  typedef logic [PR_W-1:0] pr_idx_t;

  typedef struct packed {
    pr_idx_t addr;
  } rd_req_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  valid;
  } rd_ans_t;

  // Pointer advance for a ring of `depth` slots; inc never exceeds one lap.
  function automatic int wrap_add(input int ptr, input int inc, input int depth);
    int s;
    s = ptr + inc;
    return (s >= depth) ? s - depth : s;
  endfunction
endpackage

// File: rtl/phys_reg_file_if.sv
// rtl/phys_reg_file_if.sv - alloc/free/read/write port bundle of the physical register file
interface phys_reg_file_if
  import phys_reg_file_pkg::*;
#(
  parameter int NUM_PHY_REGS = NUM_PHY_REGS_DEF,
  parameter int NUM_SICS     = 2,
  parameter int NUM_RD       = 2,
  parameter int DATA_W       = DATA_W_DEF
);
  localparam int PW = $clog2(NUM_PHY_REGS);
  localparam int CW = PW + 1;

  logic [NUM_SICS-1:0] alloc_req;
  logic [NUM_SICS-1:0] alloc_gnt;
  logic [PW-1:0]       alloc_pr  [NUM_SICS];
  logic [NUM_SICS-1:0] free_wen;
  logic [PW-1:0]       free_pr   [NUM_SICS];
  logic [PW-1:0]       rd_addr   [NUM_SICS][NUM_RD];
  logic [DATA_W-1:0]   rd_data   [NUM_SICS][NUM_RD];
  logic                rd_valid  [NUM_SICS][NUM_RD];
  logic [NUM_SICS-1:0] wr_en;
  logic [PW-1:0]       wr_addr   [NUM_SICS];
  logic [DATA_W-1:0]   wr_data   [NUM_SICS];
  logic [CW-1:0]       free_count;
  logic                err;

  modport master (
    output alloc_req, free_wen, free_pr, rd_addr, wr_en, wr_addr, wr_data,
    input  alloc_gnt, alloc_pr, rd_data, rd_valid, free_count, err
  );

  modport slave (
    input  alloc_req, free_wen, free_pr, rd_addr, wr_en, wr_addr, wr_data,
    output alloc_gnt, alloc_pr, rd_data, rd_valid, free_count, err
  );
endinterface

// File: rtl/prf_free_list.sv
// rtl/prf_free_list.sv - circular free-PR FIFO with multi-pop head view and ordered multi-push
module prf_free_list
  import phys_reg_file_pkg::*;
#(
  parameter int DEPTH      = 63,
  parameter int W          = 6,
  parameter int CW         = 7,
  parameter int NUM_PORTS  = 2,
  parameter int INIT_COUNT = 32,
  parameter int INIT_BASE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CW-1:0]        pop_cnt,
  input  logic [NUM_PORTS-1:0] push_en,
  input  logic [W-1:0]         push_data [NUM_PORTS],
  output logic [W-1:0]         head_data [NUM_PORTS],
  output logic [CW-1:0]        count,
  output logic                 overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin : head_view
    for (int k = 0; k < NUM_PORTS; k++) begin
      head_data[k] = mem_q[PTR_W'(wrap_add(int'(head_q), k, DEPTH))];
    end
  end

  // Pushes see the occupancy left after this cycle's pops, so a slot just
  // popped can be refilled on the same edge.
  always_comb begin : next_state
    int occ;
    int tail;
    mem_d    = mem_q;
    overflow = 1'b0;
    occ      = int'(count_q) - int'(pop_cnt);
    tail     = int'(tail_q);
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_en[p]) begin
        if (occ < DEPTH) begin
          mem_d[PTR_W'(tail)] = push_data[p];
          tail = wrap_add(tail, 1, DEPTH);
          occ++;
        end else begin
          overflow = 1'b1;
        end
      end
    end
    head_d  = PTR_W'(wrap_add(int'(head_q), int'(pop_cnt), DEPTH));
    tail_d  = PTR_W'(tail);
    count_d = CW'(occ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i < INIT_COUNT) ? W'(INIT_BASE + i) : '0;
      end
      head_q  <= '0;
      tail_q  <= PTR_W'(INIT_COUNT % DEPTH);
      count_q <= CW'(INIT_COUNT);
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/phys_reg_file.sv
// rtl/phys_reg_file.sv - renamed-register data array with valid bits, write bypass and PR allocator
module phys_reg_file
  import phys_reg_file_pkg::*;
#(
  parameter int NUM_PHY_REGS = NUM_PHY_REGS_DEF,
  parameter int NUM_SICS     = 2,
  parameter int NUM_RD       = 2,
  parameter int NUM_ARCH     = NUM_ARCH_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input logic             clk,
  input logic             rst,
  phys_reg_file_if.slave  bus
);
  localparam int PW = $clog2(NUM_PHY_REGS);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0]       regs_q [NUM_PHY_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_PHY_REGS];
  logic [NUM_PHY_REGS-1:0] vld_q, vld_d;
  logic                    err_q, err_d;

  logic [CW-1:0]       fl_count, grant_cnt;
  logic [PW-1:0]       fl_head [NUM_SICS];
  logic                fl_overflow;
  logic [NUM_SICS-1:0] fl_push;

  prf_free_list #(
    .DEPTH      (NUM_PHY_REGS - 1),
    .W          (PW),
    .CW         (CW),
    .NUM_PORTS  (NUM_SICS),
    .INIT_COUNT (NUM_PHY_REGS - NUM_ARCH),
    .INIT_BASE  (NUM_ARCH)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop_cnt   (grant_cnt),
    .push_en   (fl_push),
    .push_data (bus.free_pr),
    .head_data (fl_head),
    .count     (fl_count),
    .overflow  (fl_overflow)
  );

  // PR0 is the hardwired zero register and never re-enters the free list.
  always_comb begin : free_filter
    for (int s = 0; s < NUM_SICS; s++) begin
      fl_push[s] = bus.free_wen[s] && (bus.free_pr[s] != '0);
    end
  end

  always_comb begin : grant
    int n;
    n = 0;
    for (int s = 0; s < NUM_SICS; s++) begin
      bus.alloc_gnt[s] = !rst && bus.alloc_req[s] && (int'(fl_count) > n);
      bus.alloc_pr[s]  = fl_head[0];
      for (int k = 0; k < NUM_SICS; k++) begin
        if (k == n) bus.alloc_pr[s] = fl_head[k];
      end
      if (bus.alloc_gnt[s]) n++;
    end
    grant_cnt = CW'(n);
  end

  always_comb begin : read_path
    logic          hit;
    logic [PW-1:0] a;
    for (int s = 0; s < NUM_SICS; s++) begin
      for (int r = 0; r < NUM_RD; r++) begin
        a   = bus.rd_addr[s][r];
        hit = 1'b0;
        bus.rd_data[s][r]  = regs_q[a];
        bus.rd_valid[s][r] = vld_q[a];
        for (int w = 0; w < NUM_SICS; w++) begin
          if (!hit && bus.wr_en[w] && (bus.wr_addr[w] == a)) begin
            hit                = 1'b1;
            bus.rd_data[s][r]  = bus.wr_data[w];
            bus.rd_valid[s][r] = 1'b1;
          end
        end
        if (a == '0) begin
          bus.rd_data[s][r]  = '0;
          bus.rd_valid[s][r] = 1'b1;
        end
      end
    end
  end

  // Allocation clears vld first so a same-edge writeback to the new PR wins.
  always_comb begin : update
    logic          dup;
    logic [PW-1:0] a;
    regs_d = regs_q;
    vld_d  = vld_q;
    err_d  = err_q | fl_overflow;
    dup    = 1'b0;
    a      = '0;
    for (int s = 0; s < NUM_SICS; s++) begin
      if (bus.alloc_gnt[s]) vld_d[bus.alloc_pr[s]] = 1'b0;
    end
    for (int s = 0; s < NUM_SICS; s++) begin
      a   = bus.wr_addr[s];
      dup = 1'b0;
      for (int t = 0; t < NUM_SICS; t++) begin
        if (t < s && bus.wr_en[t] && (bus.wr_addr[t] == a)) dup = 1'b1;
      end
      if (bus.wr_en[s] && (a != '0)) begin
        if (vld_q[a] || dup) begin
          err_d = 1'b1;
        end else begin
          regs_d[a] = bus.wr_data[s];
          vld_d[a]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PHY_REGS; p++) begin
        regs_q[p] <= '0;
        vld_q[p]  <= (p < NUM_ARCH);
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  assign bus.free_count = fl_count;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_phys_reg_file.sv
// tb/tb_phys_reg_file.sv - directed vector table, corner sequences and queue-model random run for phys_reg_file
module tb_phys_reg_file;
  import phys_reg_file_pkg::*;

  localparam int NP = 64, NS = 2, NR = 2, NA = 32, DW = 32, DEPTH = NP - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  phys_reg_file_if #(.NUM_PHY_REGS(NP), .NUM_SICS(NS), .NUM_RD(NR), .DATA_W(DW)) bus ();

  phys_reg_file #(
    .NUM_PHY_REGS(NP), .NUM_SICS(NS), .NUM_RD(NR), .NUM_ARCH(NA), .DATA_W(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.alloc_req = '0;
    bus.free_wen  = '0;
    bus.wr_en     = '0;
    for (int s = 0; s < NS; s++) begin
      bus.free_pr[s] = '0;
      bus.wr_addr[s] = '0;
      bus.wr_data[s] = '0;
      for (int r = 0; r < NR; r++) bus.rd_addr[s][r] = '0;
    end
  endtask

  task automatic set_rd(input logic [5:0] a);
    for (int s = 0; s < NS; s++)
      for (int r = 0; r < NR; r++) bus.rd_addr[s][r] = a;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  areq, wen;
    logic [5:0]  wa0;
    logic [31:0] wd0;
    logic [5:0]  wa1;
    logic [31:0] wd1;
    logic [5:0]  ra;
    logic [1:0]  egnt;
    logic [5:0]  epr0, epr1;
    logic [31:0] erd;
    logic        ev;
    logic [6:0]  efc;
    logic        eerr;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] areq, input logic [1:0] wen,
                              input logic [5:0] wa0, input logic [31:0] wd0,
                              input logic [5:0] wa1, input logic [31:0] wd1,
                              input logic [5:0] ra, input logic [1:0] egnt,
                              input logic [5:0] epr0, input logic [5:0] epr1,
                              input logic [31:0] erd, input logic ev,
                              input logic [6:0] efc, input logic eerr);
    vec_t v;
    v.areq = areq; v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra = ra; v.egnt = egnt; v.epr0 = epr0; v.epr1 = epr1; v.erd = erd; v.ev = ev;
    v.efc = efc; v.eerr = eerr;
    return v;
  endfunction

  // Reference model: free list as a queue, registers and valid bits as arrays.
  int          mfree[$];
  logic [31:0] mregs[NP];
  bit          mvld[NP];
  bit          merr;
  int          mgrant;

  function automatic void m_reset();
    mfree.delete();
    for (int p = NA; p < NP; p++) mfree.push_back(p);
    for (int p = 0; p < NP; p++) begin
      mregs[p] = '0;
      mvld[p]  = (p < NA);
    end
    merr = 1'b0;
  endfunction

  task automatic m_check();
    int          n;
    int          a;
    bit          hit;
    logic [31:0] ed;
    bit          ev;
    n = 0;
    for (int s = 0; s < NS; s++) begin
      bit eg;
      eg = bus.alloc_req[s] && (mfree.size() > n);
      check($sformatf("rand gnt%0d", s), 64'(bus.alloc_gnt[s]), 64'(eg));
      if (eg) begin
        check($sformatf("rand alloc_pr%0d", s), 64'(bus.alloc_pr[s]), 64'(mfree[n]));
        n++;
      end
    end
    mgrant = n;
    for (int s = 0; s < NS; s++) begin
      for (int r = 0; r < NR; r++) begin
        a = int'(bus.rd_addr[s][r]);
        if (a == 0) begin
          ed = '0;
          ev = 1'b1;
        end else begin
          hit = 1'b0;
          ed  = mregs[a];
          ev  = mvld[a];
          for (int w = 0; w < NS; w++) begin
            if (!hit && bus.wr_en[w] && int'(bus.wr_addr[w]) == a) begin
              hit = 1'b1;
              ed  = bus.wr_data[w];
              ev  = 1'b1;
            end
          end
        end
        check($sformatf("rand rd_data[%0d][%0d]", s, r), 64'(bus.rd_data[s][r]), 64'(ed));
        check($sformatf("rand rd_valid[%0d][%0d]", s, r), 64'(bus.rd_valid[s][r]), 64'(ev));
      end
    end
    check("rand free_count", 64'(bus.free_count), 64'(mfree.size()));
    check("rand err", 64'(bus.err), 64'(merr));
  endtask

  function automatic void m_update();
    bit oldv[NP];
    bit taken[NP];
    int a;
    oldv = mvld;
    for (int p = 0; p < NP; p++) taken[p] = 1'b0;
    for (int g = 0; g < mgrant; g++) mvld[mfree.pop_front()] = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (bus.free_wen[s] && bus.free_pr[s] != '0) begin
        if (mfree.size() < DEPTH) mfree.push_back(int'(bus.free_pr[s]));
        else merr = 1'b1;
      end
    end
    for (int s = 0; s < NS; s++) begin
      a = int'(bus.wr_addr[s]);
      if (bus.wr_en[s] && a != 0) begin
        if (oldv[a] || taken[a]) merr = 1'b1;
        else begin
          mregs[a] = bus.wr_data[s];
          mvld[a]  = 1'b1;
          taken[a] = 1'b1;
        end
      end
    end
  endfunction

  vec_t vecs[14];
  int   pend[$];
  int   done[$];

  initial begin
    vecs[0]  = mk(2'b11, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd32, 2'b11, 6'd32, 6'd33, 32'h0,        1'b0, 7'd32, 1'b0);
    vecs[1]  = mk(2'b00, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd32, 2'b00, 6'd0,  6'd0,  32'h0,        1'b0, 7'd30, 1'b0);
    vecs[2]  = mk(2'b00, 2'b01, 6'd32, 32'hDEADBEEF, 6'd0,  32'h0, 6'd32, 2'b00, 6'd0,  6'd0,  32'hDEADBEEF, 1'b1, 7'd30, 1'b0);
    vecs[3]  = mk(2'b00, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd32, 2'b00, 6'd0,  6'd0,  32'hDEADBEEF, 1'b1, 7'd30, 1'b0);
    vecs[4]  = mk(2'b00, 2'b01, 6'd0,  32'h5,        6'd0,  32'h0, 6'd0,  2'b00, 6'd0,  6'd0,  32'h0,        1'b1, 7'd30, 1'b0);
    vecs[5]  = mk(2'b00, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd0,  2'b00, 6'd0,  6'd0,  32'h0,        1'b1, 7'd30, 1'b0);
    vecs[6]  = mk(2'b00, 2'b01, 6'd33, 32'h11,       6'd0,  32'h0, 6'd33, 2'b00, 6'd0,  6'd0,  32'h11,       1'b1, 7'd30, 1'b0);
    vecs[7]  = mk(2'b00, 2'b01, 6'd33, 32'h22,       6'd0,  32'h0, 6'd32, 2'b00, 6'd0,  6'd0,  32'hDEADBEEF, 1'b1, 7'd30, 1'b0);
    vecs[8]  = mk(2'b00, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd33, 2'b00, 6'd0,  6'd0,  32'h11,       1'b1, 7'd30, 1'b1);
    vecs[9]  = mk(2'b01, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd33, 2'b01, 6'd34, 6'd0,  32'h11,       1'b1, 7'd30, 1'b1);
    vecs[10] = mk(2'b00, 2'b11, 6'd34, 32'hA,        6'd34, 32'hB, 6'd34, 2'b00, 6'd0,  6'd0,  32'hA,        1'b1, 7'd29, 1'b1);
    vecs[11] = mk(2'b00, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd34, 2'b00, 6'd0,  6'd0,  32'hA,        1'b1, 7'd29, 1'b1);
    vecs[12] = mk(2'b01, 2'b01, 6'd35, 32'h77,       6'd0,  32'h0, 6'd35, 2'b01, 6'd35, 6'd0,  32'h77,       1'b1, 7'd29, 1'b1);
    vecs[13] = mk(2'b00, 2'b00, 6'd0,  32'h0,        6'd0,  32'h0, 6'd35, 2'b00, 6'd0,  6'd0,  32'h77,       1'b1, 7'd28, 1'b1);

    idle();
    #1 rst = 1'b1;
    bus.alloc_req     = 2'b11;
    bus.rd_addr[0][0] = 6'd5;
    bus.rd_addr[0][1] = 6'd40;
    bus.rd_addr[1][0] = 6'd0;
    bus.rd_addr[1][1] = 6'd63;
    #2;
    check("reset gnt", 64'(bus.alloc_gnt), 64'(2'b00));
    check("reset free_count", 64'(bus.free_count), 64'(32));
    check("reset err", 64'(bus.err), 64'(0));
    check("reset vld PR5", 64'(bus.rd_valid[0][0]), 64'(1));
    check("reset vld PR40", 64'(bus.rd_valid[0][1]), 64'(0));
    check("reset vld PR0", 64'(bus.rd_valid[1][0]), 64'(1));
    check("reset data PR63", 64'(bus.rd_data[1][1]), 64'(0));

    do_reset();
    for (int i = 0; i < 14; i++) begin
      idle();
      bus.alloc_req  = vecs[i].areq;
      bus.wr_en      = vecs[i].wen;
      bus.wr_addr[0] = vecs[i].wa0;
      bus.wr_data[0] = vecs[i].wd0;
      bus.wr_addr[1] = vecs[i].wa1;
      bus.wr_data[1] = vecs[i].wd1;
      set_rd(vecs[i].ra);
      @(negedge clk);
      check($sformatf("vec%0d gnt", i), 64'(bus.alloc_gnt), 64'(vecs[i].egnt));
      if (vecs[i].egnt[0]) check($sformatf("vec%0d alloc_pr0", i), 64'(bus.alloc_pr[0]), 64'(vecs[i].epr0));
      if (vecs[i].egnt[1]) check($sformatf("vec%0d alloc_pr1", i), 64'(bus.alloc_pr[1]), 64'(vecs[i].epr1));
      for (int s = 0; s < NS; s++) begin
        for (int r = 0; r < NR; r++) begin
          check($sformatf("vec%0d rd_data[%0d][%0d]", i, s, r), 64'(bus.rd_data[s][r]), 64'(vecs[i].erd));
          check($sformatf("vec%0d rd_valid[%0d][%0d]", i, s, r), 64'(bus.rd_valid[s][r]), 64'(vecs[i].ev));
        end
      end
      check($sformatf("vec%0d free_count", i), 64'(bus.free_count), 64'(vecs[i].efc));
      check($sformatf("vec%0d err", i), 64'(bus.err), 64'(vecs[i].eerr));
      next_cycle();
    end

    do_reset();
    @(negedge clk);
    check("err cleared by rst", 64'(bus.err), 64'(0));
    check("free_count after rst", 64'(bus.free_count), 64'(32));

    // Drain every free PR, then free PR40 while the list is empty.
    next_cycle();
    bus.alloc_req = 2'b11;
    repeat (16) next_cycle();
    bus.free_wen   = 2'b01;
    bus.free_pr[0] = 6'd40;
    @(negedge clk);
    check("empty gnt", 64'(bus.alloc_gnt), 64'(2'b00));
    check("empty free_count", 64'(bus.free_count), 64'(0));
    next_cycle();
    bus.free_wen = 2'b00;
    @(negedge clk);
    check("refill gnt", 64'(bus.alloc_gnt), 64'(2'b01));
    check("refill alloc_pr0", 64'(bus.alloc_pr[0]), 64'(40));
    check("refill free_count", 64'(bus.free_count), 64'(1));
    next_cycle();
    idle();
    @(negedge clk);
    check("refill drained", 64'(bus.free_count), 64'(0));

    // Free PR0 is ignored; overfilling the list drops the extra and flags err.
    do_reset();
    bus.free_wen   = 2'b11;
    bus.free_pr[0] = 6'd0;
    bus.free_pr[1] = 6'd0;
    next_cycle();
    @(negedge clk);
    check("PR0 free ignored count", 64'(bus.free_count), 64'(32));
    check("PR0 free no err", 64'(bus.err), 64'(0));
    next_cycle();
    bus.free_pr[0] = 6'd5;
    bus.free_pr[1] = 6'd5;
    repeat (15) next_cycle();
    @(negedge clk);
    check("near full count", 64'(bus.free_count), 64'(62));
    check("near full err", 64'(bus.err), 64'(0));
    next_cycle();
    idle();
    @(negedge clk);
    check("overflow count", 64'(bus.free_count), 64'(63));
    check("overflow err", 64'(bus.err), 64'(1));

    // Reset asserted in the middle of an allocation burst.
    do_reset();
    bus.alloc_req = 2'b11;
    repeat (3) next_cycle();
    @(negedge clk);
    check("burst free_count", 64'(bus.free_count), 64'(26));
    next_cycle();
    #1 rst = 1'b1;
    #1;
    check("mid-burst rst gnt", 64'(bus.alloc_gnt), 64'(2'b00));
    check("mid-burst rst free_count", 64'(bus.free_count), 64'(32));
    next_cycle();
    rst = 1'b0;
    bus.alloc_req = 2'b01;
    @(negedge clk);
    check("post-rst gnt", 64'(bus.alloc_gnt), 64'(2'b01));
    check("post-rst alloc_pr0", 64'(bus.alloc_pr[0]), 64'(32));
    check("post-rst free_count", 64'(bus.free_count), 64'(32));

    do_reset();
    m_reset();
    pend.delete();
    done.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      bus.alloc_req = 2'($urandom);
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(0, 19) == 0) begin
          bus.free_wen[s] = 1'b1;
          bus.free_pr[s]  = 6'($urandom_range(0, NP - 1));
        end else if (done.size() > 0 && $urandom_range(0, 3) == 0) begin
          int idx;
          idx = $urandom_range(0, done.size() - 1);
          bus.free_wen[s] = 1'b1;
          bus.free_pr[s]  = 6'(done[idx]);
          done.delete(idx);
        end
        if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
          bus.wr_en[s]   = 1'b1;
          bus.wr_addr[s] = 6'(pend[0]);
          done.push_back(pend.pop_front());
          bus.wr_data[s] = $urandom;
        end else if ($urandom_range(0, 15) == 0) begin
          bus.wr_en[s]   = 1'b1;
          bus.wr_addr[s] = 6'($urandom_range(0, NP - 1));
          bus.wr_data[s] = $urandom;
        end
      end
      for (int s = 0; s < NS; s++)
        for (int r = 0; r < NR; r++)
          bus.rd_addr[s][r] = ($urandom_range(0, 3) == 0) ? bus.wr_addr[$urandom_range(0, NS - 1)]
                                                          : 6'($urandom_range(0, NP - 1));
      @(negedge clk);
      m_check();
      for (int g = 0; g < mgrant; g++) pend.push_back(mfree[g]);
      m_update();
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
